// File: rtl/seven_segments_pkg.sv
// Shared types and constants for the seven-segment display multiplexer.
// Holds the slot state enum, blank pattern, input width and hex glyph table.
package seven_segments_pkg;

  typedef enum logic {
    S_BLANK,
    S_SHOW
  } state_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

`ifdef SEVEN_SEGMENTS_HEX_DECODE_EN
  localparam int SEG_IN_W = 4;
`else
  localparam int SEG_IN_W = 7;
`endif

  // Active-high glyphs, bit0=a .. bit6=g.
  localparam logic [6:0] HEX_GLYPH [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F,
    7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C,
    7'h39, 7'h5E, 7'h79, 7'h71
  };

endpackage

// File: rtl/hex_to_seven_segments.sv
// Hex nibble to active-high seven-segment glyph decoder.
// Ports: nibble (4-bit value in), segments (7-bit glyph out, bit0=a).
module hex_to_seven_segments
  import seven_segments_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] segments
);

  assign segments = HEX_GLYPH[nibble];

endmodule

// File: rtl/seven_segments_mux.sv
// Time-multiplexed seven-segment driver with dead time and PWM brightness.
// Ports: i_clock, i_reset (async high), i_segments, i_digit_enable,
//   i_brightness in; o_sev_segments, o_digit_select (active-low),
//   o_digit_index, o_frame_start out.
// Optional: define SEVEN_SEGMENTS_HEX_DECODE_EN for 4-bit hex input digits.
module seven_segments_mux
  import seven_segments_pkg::*;
#(
  parameter int NUM_DIGITS   = 2,
  parameter int SHOW_CYCLES  = 64,
  parameter int BLANK_CYCLES = 4
) (
  input  logic                             i_clock,
  input  logic                             i_reset,
  input  logic [NUM_DIGITS*SEG_IN_W-1:0]   i_segments,
  input  logic [NUM_DIGITS-1:0]            i_digit_enable,
  input  logic [3:0]                       i_brightness,
  output logic [6:0]                       o_sev_segments,
  output logic [NUM_DIGITS-1:0]            o_digit_select,
  output logic [((NUM_DIGITS>1) ?
                 $clog2(NUM_DIGITS) : 1)-1:0] o_digit_index,
  output logic                             o_frame_start
);

  localparam int IW = (NUM_DIGITS > 1) ?
                      $clog2(NUM_DIGITS) : 1;
  localparam int SW = $clog2(SHOW_CYCLES);
  localparam int BW = $clog2(BLANK_CYCLES);
  localparam int CW = (SW > BW) ? SW : BW;
  localparam int SH = SW - 4;

  localparam logic [CW-1:0] B_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0] S_LAST = CW'(SHOW_CYCLES - 1);
  localparam logic [IW-1:0] I_LAST = IW'(NUM_DIGITS - 1);

  if (NUM_DIGITS < 2 || NUM_DIGITS > 8) begin : g_bad_nd
    $error("NUM_DIGITS out of range");
  end
  if (SHOW_CYCLES < 16 ||
      (SHOW_CYCLES & (SHOW_CYCLES - 1)) != 0) begin : g_bad_sc
    $error("SHOW_CYCLES must be a power of two >= 16");
  end
  if (BLANK_CYCLES < 1) begin : g_bad_bc
    $error("BLANK_CYCLES must be >= 1");
  end

  state_t          state;
  state_t          state_n;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   cnt_n;
  logic [IW-1:0]   idx;
  logic [IW-1:0]   idx_n;
  logic            primed;
  logic            snap_take;
  logic [NUM_DIGITS*SEG_IN_W-1:0] snap_seg;
  logic [NUM_DIGITS-1:0]          snap_en;
  logic [6:0]      pat [NUM_DIGITS];
  logic [CW-1:0]   lvl;
  logic            lit;
  logic [6:0]      seg_n;
  logic [NUM_DIGITS-1:0] sel_n;

  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_dig
`ifdef SEVEN_SEGMENTS_HEX_DECODE_EN
    hex_to_seven_segments u_hex (
      .nibble   (snap_seg[k*SEG_IN_W +: SEG_IN_W]),
      .segments (pat[k])
    );
`else
    assign pat[k] = snap_seg[k*SEG_IN_W +: SEG_IN_W];
`endif
  end

  // Until the first edge after reset the sequencer is unprimed;
  // that edge is treated as entry into digit 0 blanking so the
  // first frame starts (and snapshots) immediately.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    idx_n     = idx;
    snap_take = 1'b0;
    if (!primed) begin
      state_n   = S_BLANK;
      cnt_n     = '0;
      idx_n     = '0;
      snap_take = 1'b1;
    end else begin
      unique case (state)
        S_BLANK: begin
          if (cnt == B_LAST) begin
            state_n = S_SHOW;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        S_SHOW: begin
          if (cnt == S_LAST) begin
            state_n = S_BLANK;
            cnt_n   = '0;
            if (idx == I_LAST) begin
              idx_n     = '0;
              snap_take = 1'b1;
            end else begin
              idx_n = idx + 1'b1;
            end
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
      endcase
    end
  end

  // Outputs are registered from next-state values so they line
  // up with the state registers on the same cycle.
  always_comb begin
    lvl   = cnt_n >> SH;
    lit   = (lvl <= CW'(i_brightness));
    seg_n = SEG_BLANK;
    sel_n = '1;
    if (state_n == S_SHOW && snap_en[idx_n]) begin
      sel_n[idx_n] = 1'b0;
      if (lit) seg_n = ~pat[idx_n];
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state          <= S_BLANK;
      cnt            <= '0;
      idx            <= '0;
      primed         <= 1'b0;
      snap_seg       <= '0;
      snap_en        <= '0;
      o_sev_segments <= SEG_BLANK;
      o_digit_select <= '1;
      o_frame_start  <= 1'b0;
    end else begin
      state          <= state_n;
      cnt            <= cnt_n;
      idx            <= idx_n;
      primed         <= 1'b1;
      if (snap_take) begin
        snap_seg <= i_segments;
        snap_en  <= i_digit_enable;
      end
      o_sev_segments <= seg_n;
      o_digit_select <= sel_n;
      o_frame_start  <= snap_take;
    end
  end

  assign o_digit_index = idx;

endmodule

// File: tb/tb_seven_segments_mux.sv
// Directed bench for seven_segments_mux: 4 digits, 16- and 64-cycle show.
// Works with or without SEVEN_SEGMENTS_HEX_DECODE_EN.
module tb_seven_segments_mux;

`ifdef SEVEN_SEGMENTS_HEX_DECODE_EN
  localparam int W = 4;
`else
  localparam int W = 7;
`endif

  typedef struct packed {
    logic [3:0][6:0] din;
    logic [3:0][6:0] glyph;
    logic [3:0]      en;
    logic [3:0]      br;
  } vec_t;

  logic            clk;
  logic            rst;
  logic [4*W-1:0]  segs;
  logic [3:0]      en;
  logic [3:0]      br;
  logic [6:0]      o16_seg;
  logic [3:0]      o16_sel;
  logic [1:0]      o16_idx;
  logic            o16_fs;
  logic [6:0]      o64_seg;
  logic [3:0]      o64_sel;
  logic [1:0]      o64_idx;
  logic            o64_fs;

  seven_segments_mux #(
    .NUM_DIGITS(4), .SHOW_CYCLES(16), .BLANK_CYCLES(2)
  ) u16 (
    .i_clock(clk), .i_reset(rst), .i_segments(segs),
    .i_digit_enable(en), .i_brightness(br),
    .o_sev_segments(o16_seg), .o_digit_select(o16_sel),
    .o_digit_index(o16_idx), .o_frame_start(o16_fs)
  );

  seven_segments_mux #(
    .NUM_DIGITS(4), .SHOW_CYCLES(64), .BLANK_CYCLES(2)
  ) u64 (
    .i_clock(clk), .i_reset(rst), .i_segments(segs),
    .i_digit_enable(en), .i_brightness(br),
    .o_sev_segments(o64_seg), .o_digit_select(o64_sel),
    .o_digit_index(o64_idx), .o_frame_start(o64_fs)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int p = -1;
  logic [3:0][6:0] cur_glyph;
  logic [3:0][6:0] fglyph;
  logic [3:0]      fen;
  vec_t vecs [4];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at p=%0d: got %0h expected %0h",
               name, p, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    for (int k = 0; k < 4; k++) segs[k*W +: W] = v.din[k][W-1:0];
    cur_glyph = v.glyph;
    en = v.en;
    br = v.br;
  endtask

  // Advance one clock; mirror the frame snapshot at frame start.
  task automatic step();
    @(posedge clk);
    #1;
    p++;
    if (p % 72 == 0) begin
      fglyph = cur_glyph;
      fen    = en;
    end
  endtask

  task automatic check_model();
    int pp;
    int slot;
    int q;
    logic [6:0] es;
    logic [3:0] ess;
    pp   = p % 72;
    slot = pp / 18;
    q    = pp % 18;
    es   = 7'h7F;
    ess  = 4'hF;
    if (q >= 2 && fen[slot]) begin
      ess[slot] = 1'b0;
      if ((q - 2) <= int'(br)) es = ~fglyph[slot];
    end
    chk("seg", o16_seg, es);
    chk("sel", o16_sel, ess);
    chk("idx", o16_idx, slot);
    chk("frame_start", o16_fs, pp == 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_seg", o16_seg, 7'h7F);
    chk("rst_sel", o16_sel, 4'hF);
    chk("rst_idx", o16_idx, 0);
    chk("rst_fs", o16_fs, 0);
    chk("rst_seg64", o64_seg, 7'h7F);
    @(negedge clk);
    rst = 1'b0;
    p = -1;
  endtask

  initial begin
    int lit64;
    int exp64;
    rst  = 1'b1;
    segs = '0;
    en   = '0;
    br   = '0;
    cur_glyph = '0;
    fglyph = '0;
    fen = '0;

    vecs[0].glyph = {7'h4F, 7'h5B, 7'h06, 7'h3F};
    vecs[0].en = 4'hF; vecs[0].br = 4'd15;
    vecs[1].glyph = {7'h4F, 7'h5B, 7'h06, 7'h3F};
    vecs[1].en = 4'b1010; vecs[1].br = 4'd15;
    vecs[2].glyph = {7'h4F, 7'h5B, 7'h06, 7'h3F};
    vecs[2].en = 4'hF; vecs[2].br = 4'd0;
    vecs[3].glyph = {7'h7D, 7'h6D, 7'h66, 7'h77};
    vecs[3].en = 4'b0101; vecs[3].br = 4'd7;
`ifdef SEVEN_SEGMENTS_HEX_DECODE_EN
    vecs[0].din = {7'd3, 7'd2, 7'd1, 7'd0};
    vecs[1].din = {7'd3, 7'd2, 7'd1, 7'd0};
    vecs[2].din = {7'd3, 7'd2, 7'd1, 7'd0};
    vecs[3].din = {7'd6, 7'd5, 7'd4, 7'd10};
`else
    for (int v = 0; v < 4; v++) vecs[v].din = vecs[v].glyph;
`endif

    for (int v = 0; v < 4; v++) begin
      apply(vecs[v]);
      do_reset();
      lit64 = 0;
      for (int i = 0; i < 144; i++) begin
        step();
        check_model();
        if (p < 66 && o64_seg !== 7'h7F) lit64++;
      end
      exp64 = vecs[v].en[0] ? ((vecs[v].br + 1) * 4) : 0;
      chk("lit64", lit64, exp64);
    end

    // Live brightness change and mid-frame data change.
    apply(vecs[0]);
    do_reset();
    while (p < 5) begin step(); check_model(); end
    br = 4'd0;
    step(); check_model();
    chk("br_live_off", o16_seg, 7'h7F);
    chk("br_live_sel", o16_sel, 4'hE);
    br = 4'd15;
    step(); check_model();
    chk("br_live_on", o16_seg, 7'h40);
    while (p < 23) begin step(); check_model(); end
`ifdef SEVEN_SEGMENTS_HEX_DECODE_EN
    segs[1*W +: W] = 4'd4;
`else
    segs[1*W +: W] = 7'h66;
`endif
    cur_glyph[1] = 7'h66;
    while (p < 143) begin
      step(); check_model();
      if (p == 25) chk("tear_old", o16_seg, 7'h79);
      if (p == 72) chk("tear_fs", o16_fs, 1);
      if (p == 95) chk("tear_new", o16_seg, 7'h19);
    end

    // Reset mid-show of digit 2.
    apply(vecs[0]);
    do_reset();
    while (p < 43) begin step(); check_model(); end
    chk("pre_rst_idx", o16_idx, 2);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_seg", o16_seg, 7'h7F);
    chk("mid_rst_sel", o16_sel, 4'hF);
    chk("mid_rst_idx", o16_idx, 0);
    chk("mid_rst_fs", o16_fs, 0);
    @(negedge clk);
    rst = 1'b0;
    p = -1;
    while (p < 40) begin
      step(); check_model();
      if (p == 2) chk("restart_seg", o16_seg, 7'h40);
      if (p == 38) chk("restart_idx", o16_idx, 2);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
